schem_part_sum: RTL
===================

# schem_part_sum

Streaming engine-schematic solver. Accepts the puzzle grid one ASCII character per cycle and sums every number orthogonally or diagonally adjacent to a symbol. It keeps a rolling three-row window, so adjacency across the previous, current and next rows is exact. It generalises the single-line-lookback solver with parametrised geometry, input back-pressure, end-of-stream flush, and a sticky completion/error report. It sits directly behind the testbench character streamer.

## Interface
- `MAX_COLS`, 160: maximum characters per row, excluding `\n`.
- `NUM_W`, 20: width of the number accumulator.
- `RESULT_W`, 64: width of the result.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `input_valid`  in  1  `char_in` is valid this cycle.
- `char_in`  in  8  ASCII character.
- `input_last`  in  1  qualifies the final character of the stream.
- `input_ready`  out  1  block can accept a character this cycle.
- `result`  out  RESULT_W  running, then final, sum.
- `output_valid`  out  1  `result` is final; sticky until reset.
- `error`  out  1  a row exceeded `MAX_COLS`; sticky.

## Operation
- Character classes:
  - digit: `0`–`9`.
  - blank: `.` and `\r`.
  - terminator: `\n`.
  - symbol: anything else.
- Three row banks rotate through previous (P), current (C) and next (N) roles. Each bank stores characters plus its row length. Column index ≥ length, and column -1, read as blank.
- An all-blank P is implied before the first row. An all-blank N is implied after the last row.
- States:
  - IDLE: reset state.
  - FILL: accept characters into the fill bank.
  - SCAN: evaluate row C.
  - DONE.
- IDLE→FILL on the first cycle after reset.
- FILL: a character is accepted when `input_valid && input_ready`.
  - Non-terminator: written at the column counter, which then increments.
  - Row beyond `MAX_COLS`: the character is dropped and `error` is set.
  - `\n`: closes the row and latches its length.
  - The first closed row only rotates into C; it is not scanned yet.
  - Every later closed row becomes N, then the block goes to SCAN.
- `input_last` with a non-terminator character acts as that character followed by an implicit `\n`. After the last row is scanned, a blank N is substituted and C is scanned once more. The block then enters DONE.
- SCAN visits one column per cycle, c = 0 … len_C. Per column:
  - `sym[c]` = symbol at (P,c), (C,c) or (N,c).
  - C[c] is a digit:
    - `num ← num*10 + d`, truncated to NUM_W.
    - `adj |= sym[c-1] | sym[c]`.
  - Otherwise, if a number is open:
    - `adj |= sym[c]`.
    - If `adj`, `result ← result + num`, modulo 2^RESULT_W.
    - Clear `num` and `adj`.
  - Column len_C is blank by definition, which closes a trailing number.
- After SCAN, banks rotate: P←C, C←N, and the old P becomes the fill bank. The block returns to FILL, or goes to DONE after the final scan.
- DONE: `input_ready`=0 and `output_valid`=1. Inputs are ignored.
- A stream containing only `input_last` with an empty row gives `result`=0 in DONE.

## Timing
- Reset values: `result`=0, `output_valid`=0, `error`=0, `input_ready`=0, state IDLE, all counters 0.
- `input_ready`=1 only in FILL.
  - It drops the cycle after an accepted `\n` that triggers a scan.
  - It stays low for exactly len_C+1 SCAN cycles, then rises.
- Result update latency: one cycle after the closing column.
- `output_valid` rises one cycle after the last SCAN column.
- Reset mid-SCAN or mid-FILL aborts immediately: all state returns to reset values and partial sums are discarded.
- Rows may differ in length; no padding is required from the source.

## Structure
- Package `schem_pkg`:
  - state enum;
  - character constants (`CH_DOT`, `CH_NL`, `CH_CR`);
  - functions `is_digit` and `is_symbol`.
- Sub-module `schem_row_bank`:
  - three `MAX_COLS`×8 arrays with length registers;
  - write port for the fill bank, a rotate strobe, and a three-row read at one column index.
  - It returns blank for out-of-range columns.

## Test plan
- AoC sample grid (10×10, `467..114..` …), `input_last` on the final `\n` -> `result`=4361, `output_valid`=1.
- `5..\n.*.\n` -> 5. `..5\n*..\n` -> 0 (diagonal distance 2).
- `12*\n` then `input_last` -> 12. Row without a final `\n`, `3#` with `input_last` on `#` -> 3.
- Back-pressure: two 10-column rows -> `input_ready` low for exactly 11 cycles after the second `\n`. Driving `input_valid` during that window causes no state change.
- `MAX_COLS`=8, row of 12 characters -> `error`=1, columns 8–11 ignored, `result` computed from columns 0–7.
- Assert `rst_n` low mid-SCAN of the sample grid -> all outputs 0. A full replay then still yields 4361.

Source files
------------

// File: rtl/schem_pkg.sv
// Shared types and character helpers for the streaming engine-schematic solver.
// Contents: FSM state enum, ASCII constants, digit/symbol classifiers.
package schem_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StScan, StDone} state_e;

  localparam logic [7:0] CH_DOT  = 8'h2E;
  localparam logic [7:0] CH_NL   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_ZERO = 8'h30;

  function automatic logic is_digit(logic [7:0] ch);
    return (ch >= 8'h30) && (ch <= 8'h39);
  endfunction

  // Anything that is not a digit, blank ('.', '\r') or row terminator.
  function automatic logic is_symbol(logic [7:0] ch);
    return !is_digit(ch) && (ch != CH_DOT) && (ch != CH_CR) && (ch != CH_NL);
  endfunction

endpackage

// File: rtl/schem_part_sum_if.sv
// Character-stream / result bundle for schem_part_sum.
// master: character source (drives input_valid, char_in, input_last).
// slave:  solver (drives input_ready, result, output_valid, error).
interface schem_part_sum_if #(
  parameter int unsigned RESULT_W = 64
) ();
  logic                input_valid;
  logic [7:0]          char_in;
  logic                input_last;
  logic                input_ready;
  logic [RESULT_W-1:0] result;
  logic                output_valid;
  logic                error;

  modport master (
    output input_valid, char_in, input_last,
    input  input_ready, result, output_valid, error
  );

  modport slave (
    input  input_valid, char_in, input_last,
    output input_ready, result, output_valid, error
  );
endinterface

// File: rtl/schem_row_bank.sv
// Three rotating row buffers playing previous (P), current (C) and next (N) roles.
// Ports: clk, rst_n; write port into the N (fill) bank; len_we_i latches the N length;
// rotate_i moves P<-C, C<-N, N<-old P and clears the new N length; rd_col_i reads all
// three rows at one column, out-of-range columns return '.'; c_len_o is C's length.
module schem_row_bank
  import schem_pkg::*;
#(
  parameter int unsigned MAX_COLS = 160,
  localparam int unsigned LW = $clog2(MAX_COLS + 1),
  localparam int unsigned AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_col_i,
  input  logic [7:0]    wr_char_i,
  input  logic          len_we_i,
  input  logic [LW-1:0] len_i,
  input  logic          rotate_i,
  input  logic [LW-1:0] rd_col_i,
  output logic [7:0]    p_ch_o,
  output logic [7:0]    c_ch_o,
  output logic [7:0]    n_ch_o,
  output logic [LW-1:0] c_len_o
);

  logic [7:0]    mem_q [3][MAX_COLS];
  logic [LW-1:0] len_q [3];
  logic [LW-1:0] len_d [3];
  logic [1:0]    p_sel_q, c_sel_q, n_sel_q;
  logic [1:0]    p_sel_d, c_sel_d, n_sel_d;
  logic [AW-1:0] rd_addr;

  always_comb begin
    p_sel_d = p_sel_q;
    c_sel_d = c_sel_q;
    n_sel_d = n_sel_q;
    for (int i = 0; i < 3; i++) begin
      len_d[i] = len_q[i];
      if (len_we_i && (n_sel_q == 2'(i))) len_d[i] = len_i;
      // The recycled bank becomes the new N: empty until refilled, so it reads blank.
      if (rotate_i && (p_sel_q == 2'(i))) len_d[i] = '0;
    end
    if (rotate_i) begin
      p_sel_d = c_sel_q;
      c_sel_d = n_sel_q;
      n_sel_d = p_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) len_q[i] <= '0;
      p_sel_q <= 2'd0;
      c_sel_q <= 2'd1;
      n_sel_q <= 2'd2;
    end else begin
      for (int i = 0; i < 3; i++) len_q[i] <= len_d[i];
      p_sel_q <= p_sel_d;
      c_sel_q <= c_sel_d;
      n_sel_q <= n_sel_d;
    end
  end

  // Character storage needs no reset: the length registers mask stale contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[n_sel_q][wr_col_i] <= wr_char_i;
  end

  assign rd_addr = rd_col_i[AW-1:0];
  assign p_ch_o  = (rd_col_i < len_q[p_sel_q]) ? mem_q[p_sel_q][rd_addr] : CH_DOT;
  assign c_ch_o  = (rd_col_i < len_q[c_sel_q]) ? mem_q[c_sel_q][rd_addr] : CH_DOT;
  assign n_ch_o  = (rd_col_i < len_q[n_sel_q]) ? mem_q[n_sel_q][rd_addr] : CH_DOT;
  assign c_len_o = len_q[c_sel_q];

endmodule

// File: rtl/schem_part_sum.sv
// Streaming engine-schematic solver: sums every number touching a symbol (8-neighbour)
// using a rolling three-row window.
// Ports: clk, rst_n (async, active-low); bus (slave): input_valid/char_in/input_last
// with input_ready back-pressure, result (running then final sum), output_valid
// (sticky done), error (sticky row-overflow).
module schem_part_sum
  import schem_pkg::*;
#(
  parameter int unsigned MAX_COLS = 160,
  parameter int unsigned NUM_W    = 20,
  parameter int unsigned RESULT_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  schem_part_sum_if.slave bus
);

  localparam int unsigned LW = $clog2(MAX_COLS + 1);
  localparam int unsigned AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  state_e              state_q, state_d;
  logic [LW-1:0]       col_q, col_d;
  logic [LW-1:0]       scan_col_q, scan_col_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic                adj_q, adj_d;
  logic                prev_sym_q, prev_sym_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                last_q, last_d;
  logic                fin_q, fin_d;
  logic                have_c_q, have_c_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                ovalid_q, ovalid_d;

  logic          accept, is_nl, col_ok, sym_cur;
  logic          wr_en, len_we, rotate;
  logic [LW-1:0] len_val;
  logic [7:0]    p_ch, c_ch, n_ch, digit;
  logic [LW-1:0] c_len;

  schem_row_bank #(
    .MAX_COLS (MAX_COLS)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_col_i  (col_q[AW-1:0]),
    .wr_char_i (bus.char_in),
    .len_we_i  (len_we),
    .len_i     (len_val),
    .rotate_i  (rotate),
    .rd_col_i  (scan_col_q),
    .p_ch_o    (p_ch),
    .c_ch_o    (c_ch),
    .n_ch_o    (n_ch),
    .c_len_o   (c_len)
  );

  assign accept  = bus.input_valid && ready_q;
  assign is_nl   = (bus.char_in == CH_NL);
  assign col_ok  = (col_q < LW'(MAX_COLS));
  assign sym_cur = is_symbol(p_ch) || is_symbol(c_ch) || is_symbol(n_ch);
  assign digit   = c_ch - CH_ZERO;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_col_d = scan_col_q;
    num_d      = num_q;
    adj_d      = adj_q;
    prev_sym_d = prev_sym_q;
    result_d   = result_q;
    last_d     = last_q;
    fin_d      = fin_q;
    have_c_d   = have_c_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    len_we     = 1'b0;
    rotate     = 1'b0;
    len_val    = (!is_nl && col_ok) ? col_q + 1'b1 : col_q;

    unique case (state_q)
      StIdle: state_d = StFill;

      StFill: begin
        if (accept) begin
          if (!is_nl) begin
            if (col_ok) begin
              wr_en = 1'b1;
              col_d = col_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          // input_last on a non-terminator implies a trailing '\n'.
          if (is_nl || bus.input_last) begin
            len_we = 1'b1;
            col_d  = '0;
            last_d = bus.input_last;
            if (!have_c_q) begin
              // First row only becomes C; a single-row stream scans it against blank N.
              rotate   = 1'b1;
              have_c_d = 1'b1;
              if (bus.input_last) begin
                fin_d      = 1'b1;
                state_d    = StScan;
                scan_col_d = '0;
                prev_sym_d = 1'b0;
              end
            end else begin
              state_d    = StScan;
              scan_col_d = '0;
              prev_sym_d = 1'b0;
            end
          end
        end
      end

      StScan: begin
        if (is_digit(c_ch)) begin
          num_d = num_q * NUM_W'(10) + NUM_W'(digit);
          adj_d = adj_q | prev_sym_q | sym_cur;
        end else begin
          // With no number open num_q is zero, so this adds nothing.
          if (adj_q || sym_cur) result_d = result_q + RESULT_W'(num_q);
          num_d = '0;
          adj_d = 1'b0;
        end
        prev_sym_d = sym_cur;
        if (scan_col_q == c_len) begin
          scan_col_d = '0;
          prev_sym_d = 1'b0;
          if (fin_q) begin
            state_d = StDone;
          end else begin
            rotate = 1'b1;
            // After the last row arrives, rescan once more with the cleared N as blank.
            if (last_q) fin_d = 1'b1;
            else        state_d = StFill;
          end
        end else begin
          scan_col_d = scan_col_q + 1'b1;
        end
      end

      StDone: ;

      default: state_d = StIdle;
    endcase

    ready_d  = (state_d == StFill);
    ovalid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      scan_col_q <= '0;
      num_q      <= '0;
      adj_q      <= 1'b0;
      prev_sym_q <= 1'b0;
      result_q   <= '0;
      last_q     <= 1'b0;
      fin_q      <= 1'b0;
      have_c_q   <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      ovalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_col_q <= scan_col_d;
      num_q      <= num_d;
      adj_q      <= adj_d;
      prev_sym_q <= prev_sym_d;
      result_q   <= result_d;
      last_q     <= last_d;
      fin_q      <= fin_d;
      have_c_q   <= have_c_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      ovalid_q   <= ovalid_d;
    end
  end

  assign bus.input_ready  = ready_q;
  assign bus.result       = result_q;
  assign bus.output_valid = ovalid_q;
  assign bus.error        = err_q;

endmodule
